// File: rtl/adder_io_stage.sv
// adder_io_stage: a two-entry operand FIFO feeds an external combinational
// adder. The sum, the carry and a signed-overflow flag are captured into a
// registered output stage that uses a valid/ready handshake. The stage also
// counts completed output handshakes.
module adder_io_stage #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_a,
  input  logic [width-1:0] in_b,
  output logic [width-1:0] op_a,
  output logic [width-1:0] op_b,
  input  logic [width-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [15:0]      out_cnt
);

  // Operand storage. It has no reset: the pointers and the count decide
  // which entries hold valid data.
  logic [width-1:0] r_fifo_a [0:1];
  logic [width-1:0] r_fifo_b [0:1];

  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  logic             r_out_valid;
  logic [width-1:0] r_out_sum;
  logic             r_out_cout;
  logic             r_out_ovf;
  logic [15:0]      r_out_cnt;

  logic             w_push;
  logic             w_load;
  logic             w_out_fire;
  logic             w_ovf;
  logic             w_not_empty;

  // in_ready depends only on the registered count. This keeps out_ready off
  // the upstream ready path.
  assign in_ready    = (r_count < 2'd2);
  assign w_not_empty = (r_count != 2'd0);
  assign w_push      = in_valid && in_ready;
  assign w_out_fire  = r_out_valid && out_ready;
  // The head moves into the output stage when that stage is empty or is
  // being drained in this same cycle.
  assign w_load      = w_not_empty && (!r_out_valid || out_ready);

  // The head entry drives the external adder. Zeros are driven while the
  // FIFO is empty so the adder inputs never carry stale data.
  assign op_a = w_not_empty ? r_fifo_a[r_rd_ptr] : '0;
  assign op_b = w_not_empty ? r_fifo_b[r_rd_ptr] : '0;

  // Signed overflow: the operands have the same sign and the sum sign differs.
  assign w_ovf = (op_a[width-1] == op_b[width-1]) &&
                 (add_sum[width-1] != op_a[width-1]);

  // Each FIFO slot is written only when the write pointer selects it.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      // Capture the incoming operand pair into this slot on push.
      always_ff @(posedge clk) begin
        if (w_push && (r_wr_ptr == 1'(gi))) begin
          r_fifo_a[gi] <= in_a;
          r_fifo_b[gi] <= in_b;
        end
      end
    end
  endgenerate

  // FIFO pointers and occupancy. A push and a pop in the same cycle leave the
  // count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_load) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output stage. It loads the adder result when the head pops. It clears
  // valid after a handshake with no new load, and otherwise holds its value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
      r_out_ovf   <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= add_sum;
      r_out_cout  <= add_cout;
      r_out_ovf   <= w_ovf;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  // Count completed output handshakes. The count wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_cnt <= 16'h0000;
    end else if (w_out_fire) begin
      r_out_cnt <= r_out_cnt + 16'h0001;
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;
  assign out_ovf   = r_out_ovf;
  assign out_cnt   = r_out_cnt;

endmodule

// File: tb/tb_adder_io_stage.sv
// tb_adder_io_stage: directed and streaming checks of adder_io_stage. The
// external adder is modelled here. Expected results come from hand-written
// constants or from the bench's own arithmetic.
module tb_adder_io_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] add_sum;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic [15:0]  out_cnt;

  int total = 0;
  int bad   = 0;

  logic [W+1:0] exp_q [$];   // {ovf, cout, sum} in push order
  logic [W+1:0] nxt_exp;
  int           hs_total;
  int           pushes_total;
  bit           verbose;

  adder_io_stage #(.width(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .op_a      (op_a),
    .op_b      (op_b),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;

  // External combinational adder, carry-in 0.
  assign {add_cout, add_sum} = {1'b0, op_a} + {1'b0, op_b};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W+1:0] calc(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    logic       ovf;
    s   = {1'b0, a} + {1'b0, b};
    ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return {ovf, s[W], s[W-1:0]};
  endfunction

  // Called at a negedge. Scores a handshake, records a push, then advances
  // one clock and returns at the next negedge.
  task automatic step();
    logic [W+1:0] got;
    logic [W+1:0] e;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_result", 64'(exp_q.size()), 64'd1);
      end else begin
        got = {out_ovf, out_cout, out_sum};
        e   = exp_q.pop_front();
        chk("result", 64'(got), 64'(e));
        if (verbose)
          $display("txn %0d: sum=%08h cout=%0b ovf=%0b (exp sum=%08h cout=%0b ovf=%0b)",
                   hs_total, out_sum, out_cout, out_ovf, e[W-1:0], e[W], e[W+1]);
      end
      hs_total++;
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(nxt_exp);
      pushes_total++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one pair, wait a bounded time for acceptance, then continue.
  task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W+1:0] e);
    bit pushed;
    pushed   = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    nxt_exp  = e;
    for (int i = 0; i < 20 && !pushed; i++) begin
      if (in_ready) pushed = 1'b1;
      step();
    end
    in_valid = 1'b0;
    if (!pushed) chk("push_timeout", 64'(pushed), 64'd1);
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && (exp_q.size() != 0 || out_valid); i++) step();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ready_drop;
    int pushes;
    in_valid     = 1'b0;
    in_a         = '0;
    in_b         = '0;
    out_ready    = 1'b0;
    nxt_exp      = '0;
    hs_total     = 0;
    pushes_total = 0;
    verbose      = 1'b1;

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_opa",   64'(op_a), 64'd0);
    chk("rst_opb",   64'(op_b), 64'd0);
    chk("rst_sum",   64'(out_sum), 64'd0);
    chk("rst_cnt",   64'(out_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single add. The first push lands on the first edge after reset release.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 32'h0000_0005;
    in_b      = 32'h0000_0003;
    nxt_exp   = {1'b0, 1'b0, 32'h0000_0008};
    step();
    in_valid = 1'b0;
    chk("lat_head",  64'(op_a), 64'h5);
    chk("lat_wait",  64'(out_valid), 64'd0);
    step();
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("single_sum", 64'(out_sum), 64'h8);
    step();
    chk("single_cnt",   64'(out_cnt), 64'd1);
    chk("single_clear", 64'(out_valid), 64'd0);
    chk("single_hold",  64'(out_sum), 64'h8);
    chk("empty_opa",    64'(op_a), 64'd0);

    // Carry and overflow boundaries, pushed back to back
    push_pair(32'hFFFF_FFFF, 32'h0000_0001, {1'b0, 1'b1, 32'h0000_0000});
    push_pair(32'h7FFF_FFFF, 32'h0000_0001, {1'b1, 1'b0, 32'h8000_0000});
    drain(10);
    chk("co_cnt", 64'(out_cnt), 64'd3);

    // Backpressure: three pairs with the output stalled
    out_ready = 1'b0;
    push_pair(32'h0000_0001, 32'h0000_0002, {1'b0, 1'b0, 32'h0000_0003});
    push_pair(32'h8000_0000, 32'h8000_0000, {1'b1, 1'b1, 32'h0000_0000});
    push_pair(32'h1234_5678, 32'h1111_1111, {1'b0, 1'b0, 32'h2345_6789});
    chk("bp_valid", 64'(out_valid), 64'd1);
    chk("bp_ready", 64'(in_ready), 64'd0);
    chk("bp_sum",   64'(out_sum), 64'h3);
    chk("bp_head",  64'(op_a), 64'h8000_0000);
    step();
    step();
    chk("bp_hold_sum",   64'(out_sum), 64'h3);
    chk("bp_hold_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_stream_valid", 64'(out_valid), 64'd1);
      step();
    end
    chk("bp_done_valid", 64'(out_valid), 64'd0);
    chk("bp_cnt", 64'(out_cnt), 64'd6);
    chk("bp_queue", 64'(exp_q.size()), 64'd0);

    // Reset mid-flight: two pairs buffered and a result pending
    out_ready = 1'b0;
    push_pair(32'h0000_000A, 32'h0000_000B, {1'b0, 1'b0, 32'h0000_0015});
    push_pair(32'h0000_0010, 32'h0000_0020, {1'b0, 1'b0, 32'h0000_0030});
    push_pair(32'h0000_0100, 32'h0000_0200, {1'b0, 1'b0, 32'h0000_0300});
    chk("mid_pre_valid", 64'(out_valid), 64'd1);
    chk("mid_pre_ready", 64'(in_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_valid", 64'(out_valid), 64'd0);
    chk("mid_ready", 64'(in_ready), 64'd1);
    chk("mid_cnt",   64'(out_cnt), 64'd0);
    chk("mid_opa",   64'(op_a), 64'd0);
    chk("mid_sum",   64'(out_sum), 64'd0);
    exp_q.delete();
    hs_total     = 0;
    pushes_total = 0;
    @(negedge clk);
    rst = 1'b0;

    // Streaming: 100 random pairs, both sides always ready
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    pushes     = 0;
    ready_drop = 0;
    for (int i = 0; i < 400 && pushes < 100; i++) begin
      in_a    = $urandom;
      in_b    = $urandom;
      nxt_exp = calc(in_a, in_b);
      if (in_ready) pushes++;
      else          ready_drop++;
      step();
    end
    in_valid = 1'b0;
    drain(10);
    chk("stream_pushes", 64'(pushes), 64'd100);
    chk("stream_ready",  64'(ready_drop), 64'd0);
    chk("stream_cnt",    64'(out_cnt), 64'd100);

    // Counter wrap: continue to 65535 handshakes, then one more
    verbose = 1'b0;
    $display("wrap phase: streaming to 65535 handshakes (per-transaction lines suppressed)");
    for (int i = 0; i < 70000 && hs_total < 65535; i++) begin
      in_valid = (pushes_total < 65535);
      in_a     = $urandom;
      in_b     = $urandom;
      nxt_exp  = calc(in_a, in_b);
      step();
    end
    in_valid = 1'b0;
    chk("wrap_hs",  64'(hs_total), 64'd65535);
    chk("wrap_max", 64'(out_cnt), 64'hFFFF);
    verbose = 1'b1;
    push_pair(32'h0000_0001, 32'h0000_0001, {1'b0, 1'b0, 32'h0000_0002});
    drain(10);
    chk("wrap_zero", 64'(out_cnt), 64'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_io_stage.md
ADDER_IO_STAGE -- requirements
Module: adder_io_stage

Interface
REQ-001 Parameter: width, 32, operand/sum width in bits; legal values are multiples of 4, minimum 4.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  upstream operand pair valid.
REQ-005 Port: in_ready  output  1  stage can accept an operand pair this cycle.
REQ-006 Port: in_a  input  width  operand A.
REQ-007 Port: in_b  input  width  operand B.
REQ-008 Port: op_a  output  width  operand A driven to the external combinational adder.
REQ-009 Port: op_b  output  width  operand B driven to the external combinational adder.
REQ-010 Port: add_sum  input  width  sum returned by the external adder (carry-in fixed 0).
REQ-011 Port: add_cout  input  1  carry-out returned by the external adder.
REQ-012 Port: out_valid  output  1  registered result valid.
REQ-013 Port: out_ready  input  1  downstream accepts result.
REQ-014 Port: out_sum  output  width  registered sum.
REQ-015 Port: out_cout  output  1  registered unsigned carry-out.
REQ-016 Port: out_ovf  output  1  registered two's-complement overflow flag.
REQ-017 Port: out_cnt  output  16  count of completed output handshakes.

Function
REQ-018 Input side SHALL be a 2-entry FIFO of {in_a,in_b}; push when in_valid && in_ready.
REQ-019 in_ready SHALL equal (fifo_count < 2), derived from registered count only, no combinational path from out_ready.
REQ-020 op_a/op_b SHALL present the FIFO head entry; when FIFO empty they SHALL be all zeros.
REQ-021 Load condition: fifo_count != 0 && (!out_valid || out_ready); on load, head is popped and add_sum, add_cout, ovf captured into output registers, out_valid set.
REQ-022 out_ovf SHALL be (op_a[width-1] == op_b[width-1]) && (add_sum[width-1] != op_a[width-1]), evaluated on head operands at load.
REQ-023 If out_valid && out_ready and no load, out_valid SHALL clear; out_sum/out_cout/out_ovf hold last values.
REQ-024 Output registers SHALL hold stable while out_valid && !out_ready (no overwrite, no pop).
REQ-025 Latency: pair accepted at edge N SHALL appear with out_valid at edge N+1 when FIFO was empty and output free; sustained throughput one result per cycle.
REQ-026 Simultaneous push and pop in the same cycle SHALL leave fifo_count unchanged and preserve order; push when full never occurs (in_ready low).
REQ-027 FIFO read/write pointers SHALL be 1-bit and wrap; fifo_count SHALL be 2 bits, range 0..2.
REQ-028 out_cnt SHALL increment by 1 on each out_valid && out_ready cycle, wrapping 16'hFFFF -> 16'h0000.
REQ-029 Transaction order SHALL be strictly FIFO; no pair dropped or duplicated.

Reset
REQ-030 On rst high, asynchronously: fifo_count=0, pointers=0, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_cnt=0; hence in_ready=1 and op_a=op_b=0.
REQ-031 Reset asserted mid-operation SHALL discard all buffered and output data; no output handshake counts for the reset cycle.
REQ-032 First push SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-033 Single add: width=32, push A=0x0000_0005, B=0x0000_0003, out_ready=1 -> next cycle out_valid=1, out_sum=0x8, out_cout=0, out_ovf=0, out_cnt=1 after handshake.
REQ-034 Carry/overflow: A=0xFFFF_FFFF,B=0x1 -> sum 0x0, cout=1, ovf=0; A=0x7FFF_FFFF,B=0x1 -> sum 0x8000_0000, cout=0, ovf=1.
REQ-035 Backpressure: out_ready=0, push 3 pairs -> out_valid=1 holding pair 1, fifo holds 2, in_ready=0; then out_ready=1 -> results emerge in order, one per cycle.
REQ-036 Streaming: in_valid and out_ready held 1 for 100 random pairs -> 100 results in order, in_ready never 0, out_cnt=100.
REQ-037 Reset mid-flight: 2 pairs buffered, out_valid=1, assert rst -> out_valid=0, in_ready=1, out_cnt=0 immediately without clock edge.
REQ-038 Counter wrap: preload via 65536 handshakes -> out_cnt returns to 0x0000.
